// File: rtl/out_port_buffered.sv
// Buffered datapath output port: DEPTH-entry FWFT FIFO drained by a
// valid/ready device, with a legacy last-value register and status flags.
module out_port_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             OutPortenable,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dev_data,
  output logic             dev_valid,
  input  logic             dev_ready,
  output logic [WIDTH-1:0] last_value,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             enq;
  logic             deq;
  logic             drop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign dev_valid = !empty;
  assign dev_data  = mem[rptr];

  // full implies valid, so a full-time write is covered by a real dequeue
  assign deq  = dev_valid & dev_ready;
  assign enq  = OutPortenable & (!full | dev_ready);
  assign drop = OutPortenable & full & !dev_ready;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      last_value <= '0;
      overflow   <= 1'b0;
    end else begin
      if (enq) begin
        mem[wptr]  <= BusMuxOut;
        last_value <= BusMuxOut;
        wptr       <= wptr + AW'(1);
      end
      if (deq) begin
        rptr <= rptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // a drop on the same edge as ovf_clr keeps the flag set
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_out_port_buffered.sv
// Directed self-checking bench for out_port_buffered
// (DEPTH=4, WIDTH=32), hand-computed expectations.
module tb_out_port_buffered;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        OutPortenable;
  logic        ovf_clr;
  logic [31:0] dev_data;
  logic        dev_valid;
  logic        dev_ready;
  logic [31:0] last_value;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int errs   = 0;
  int checks = 0;

  out_port_buffered #(.WIDTH(32), .DEPTH(4)) dut (
    .clock         (clock),
    .clear         (clear),
    .BusMuxOut     (BusMuxOut),
    .OutPortenable (OutPortenable),
    .ovf_clr       (ovf_clr),
    .dev_data      (dev_data),
    .dev_valid     (dev_valid),
    .dev_ready     (dev_ready),
    .last_value    (last_value),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic rdy);
    BusMuxOut     = d;
    OutPortenable = 1'b1;
    dev_ready     = rdy;
    step();
    OutPortenable = 1'b0;
    dev_ready     = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int          nxt;
    int          rexp;
    int          mcnt;
    bit          en;
    bit          rdy;
    bit          me;
    bit          md;
    int          cyc;

    clear         = 1'b1;
    BusMuxOut     = '0;
    OutPortenable = 1'b0;
    ovf_clr       = 1'b0;
    dev_ready     = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(dev_valid), 0);
    chk("rst_data", dev_data, 0);
    chk("rst_last", last_value, 0);
    chk("rst_ovf", 32'(overflow), 0);
    #10;
    clear = 1'b0;

    // single word
    wr(32'h0000_00A5, 1'b0);
    chk("one_valid", 32'(dev_valid), 1);
    chk("one_data", dev_data, 32'hA5);
    chk("one_last", last_value, 32'hA5);
    chk("one_count", 32'(count), 1);
    dev_ready = 1'b1;
    step();
    dev_ready = 1'b0;
    chk("one_empty", 32'(empty), 1);
    chk("one_cnt0", 32'(count), 0);

    // fill and overflow
    for (int i = 1; i <= 4; i++) wr(32'(i), 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 4);
    wr(32'd5, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_last", last_value, 4);
    chk("drop_count", 32'(count), 4);
    chk("drop_head", dev_data, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // full with simultaneous write and read
    wr(32'd9, 1'b1);
    chk("sim_count", 32'(count), 4);
    chk("sim_ovf", 32'(overflow), 0);
    chk("sim_last", last_value, 9);
    begin
      logic [31:0] exp_q [4];
      exp_q = '{32'd2, 32'd3, 32'd4, 32'd9};
      for (int i = 0; i < 4; i++) begin
        chk("drain_data", dev_data, exp_q[i]);
        dev_ready = 1'b1;
        step();
      end
      dev_ready = 1'b0;
    end
    chk("drain_empty", 32'(empty), 1);

    // wrap and ordering under a fixed ready pattern
    pat  = 16'b1011_0010_1110_0101;
    nxt  = 'h10;
    rexp = 'h10;
    mcnt = 0;
    cyc  = 0;
    while (rexp <= 'h19 && cyc < 100) begin
      en  = (nxt <= 'h19);
      rdy = pat[cyc % 16];
      OutPortenable = en;
      BusMuxOut     = 32'(nxt);
      dev_ready     = rdy;
      me = en && (mcnt < 4 || rdy);
      md = (mcnt > 0) && rdy;
      if (md) begin
        chk("wrap_data", dev_data, 32'(rexp));
        rexp++;
      end
      if (me) nxt++;
      mcnt = mcnt + int'(me) - int'(md);
      step();
      chk("wrap_count", 32'(count), 32'(mcnt));
      cyc++;
    end
    OutPortenable = 1'b0;
    dev_ready     = 1'b0;
    chk("wrap_done", 32'(rexp), 32'h1A);
    chk("wrap_empty", 32'(empty), 1);

    // enqueue and dequeue together at count 1
    wr(32'h7, 1'b0);
    chk("c1_head", dev_data, 7);
    wr(32'h8, 1'b1);
    chk("c1_data", dev_data, 8);
    chk("c1_count", 32'(count), 1);
    chk("c1_valid", 32'(dev_valid), 1);
    dev_ready = 1'b1;
    step();
    dev_ready = 1'b0;

    // asynchronous reset mid-operation
    wr(32'h21, 1'b0);
    wr(32'h22, 1'b0);
    wr(32'h23, 1'b0);
    wr(32'h24, 1'b0);
    overflow_set: begin
      wr(32'h25, 1'b0);
    end
    chk("pre_rst_count", 32'(count), 4);
    #2;
    clear = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_valid", 32'(dev_valid), 0);
    chk("ar_last", last_value, 0);
    chk("ar_ovf", 32'(overflow), 0);
    chk("ar_data", dev_data, 0);
    #1;
    clear = 1'b0;
    wr(32'h33, 1'b0);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_data", dev_data, 32'h33);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/out_port_buffered.md
# out_port_buffered

Parametrised, buffered output port for the RISC datapath. It replaces the single-register out port with a `DEPTH`-entry FIFO between the datapath bus and an external device. The datapath writes words with `OutPortenable`, and the device drains them through a valid/ready handshake. The block also keeps a legacy latched copy of the last accepted word, plus full, empty, count and overflow status for software polling.

## Interface
Parameters:
- `WIDTH`, default 32: data word width; matches the datapath bus.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset; asynchronous and active-high.
- `BusMuxOut`  in  WIDTH  datapath bus; sampled when `OutPortenable` = 1.
- `OutPortenable`  in  1  write strobe; one word offered per rising edge while high.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `dev_data`  out  WIDTH  head-of-FIFO word; first-word-fall-through.
- `dev_valid`  out  1  `dev_data` holds a valid word; equals `!empty`.
- `dev_ready`  in  1  device accepts `dev_data` on this rising edge.
- `last_value`  out  WIDTH  most recently accepted write (legacy out-port register).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  CW  number of stored words, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- Storage is a circular buffer `mem[DEPTH]` with a write pointer, a read pointer and `count`. Pointers are `$clog2(DEPTH)` bits wide and wrap from DEPTH-1 to 0 naturally.
- Dequeue (`deq`) = `dev_valid & dev_ready`. It advances the read pointer.
- Enqueue (`enq`) = `OutPortenable & (!full | dev_ready)`.
  - On enqueue, write `mem[wptr]` and `last_value` from `BusMuxOut`, then advance the write pointer.
  - When full, a write is accepted only if a dequeue happens on the same edge.
- Count update:
  - `count` += 1 on enqueue only.
  - `count` −= 1 on dequeue only.
  - Unchanged when both or neither occur.
- Dropped write: `OutPortenable & full & !dev_ready`.
  - Sets `overflow`.
  - FIFO contents, pointers and `last_value` stay unchanged.
- `overflow` handling:
  - Cleared by `ovf_clr`.
  - If `ovf_clr` and a dropped write occur on the same edge, set wins.
- `dev_data` = `mem[rptr]` (combinational read of the head entry).
  - Its value when `empty` is don't-care, but it must be stable (no X after reset; memory is reset to 0).
- Data ordering is strict FIFO. No reordering or merging.
- The device must hold `dev_ready` meaningful only while `dev_valid` = 1. A `dev_ready` asserted when `empty` has no effect.

## Timing
- Reset (`clear` = 1, asynchronous) puts the outputs in the following state:
  - `count` = 0, `empty` = 1, `full` = 0.
  - `dev_valid` = 0, `dev_data` = 0, `last_value` = 0, `overflow` = 0.
  - Both pointers = 0, `mem` = 0.
- Reset asserted mid-operation discards all stored words immediately, with no edge required. The first edge after deassertion behaves as if the FIFO were freshly empty.
- Write-to-visible latency is 1 cycle. A word enqueued at edge N appears on `dev_data` with `dev_valid` = 1 after edge N; there is no same-cycle bypass when empty.
- Handshake throughput: one word per cycle in each direction when both sides stream.
- A write and a read on the same edge when `count` = 1:
  - The new word becomes head after the edge.
  - `count` stays 1.
- Status outputs (`full`, `empty`, `count`, `dev_valid`) change only on rising edges or on reset assertion.
- `overflow` sets on the edge of the dropped write and stays set until `ovf_clr` or `clear`.

## Test plan
- Reset: load 3 words, then pulse `clear` between edges → `count` = 0, `empty` = 1, `dev_valid` = 0, `last_value` = 0, `overflow` = 0, with no clock edge required.
- Single word: write 0x0000_00A5 with `dev_ready` = 0.
  - Next cycle: `dev_valid` = 1, `dev_data` = 0x0000_00A5, `last_value` = 0x0000_00A5, `count` = 1.
  - Raise `dev_ready` for one edge → `empty` = 1.
- Fill and overflow (DEPTH = 4, `dev_ready` = 0): write 1, 2, 3, 4 → `full` = 1, `count` = 4.
  - Write 5 → dropped; `overflow` = 1, `last_value` = 4, `count` = 4.
  - Pulse `ovf_clr` → `overflow` = 0.
- Full with simultaneous traffic: from full {1,2,3,4}, write 9 while `dev_ready` = 1 on the same edge.
  - After the edge: `count` = 4, `overflow` = 0, head = 2.
  - Draining yields 2, 3, 4, 9.
- Pointer wrap and ordering: write 0x10..0x19 (10 words) while toggling `dev_ready` with a pseudo-random pattern.
  - The device receives 0x10..0x19 in order.
  - `count` never exceeds 4 and never underflows.
- Simultaneous enqueue/dequeue at `count` = 1: head 0x7, write 0x8 with `dev_ready` = 1 → after the edge `dev_data` = 0x8, `count` = 1, `dev_valid` = 1.
